output_regfile_packer: RTL and testbench
========================================

Name: output_regfile_packer

Overview:
- Write-back counterpart of the input regfile: captures one 16-lane 8-bit result tile from the PE array and returns it to the In_Out_buffer as 8-byte beats.
- Each beat carries a beat index, Bm_cnt_out; the buffer uses it as a write offset of Bm_cnt_out*8.
- Sits between the PE_Array output stage and the In_Out_buffer write port.
- Holds a two-tile ping-pong store, so the PE array can finish the next tile while the previous one drains.

Parameters:
- LANES, 16, PE result lanes per tile (8 bits each)
- BEAT, 8, bytes per output beat; LANES/BEAT = 2 beats per tile
- DEPTH, 2, tile store entries
- BM_BEATS, 32, beats per batch before Bm_cnt_out wraps (fits 6-bit index, 256-byte buffer window)

Ports:
- clk_cal  in  1  calculation clock
- rst_cal  in  1  reset, asynchronous, active-high
- layer_start  in  1  synchronous clear pulse at layer start
- PE_Data_I  in  128  result tile; lane n in bits [8n+7:8n]
- PE_Data_I_vld  in  1  one-cycle tile-valid pulse
- pe_stall  out  1  store full; PE array must hold its next tile
- OR_Data_O  out  64  beat data; byte m in bits [8m+7:8m]
- OR_Data_O_vld  out  1  beat valid
- OR_Data_O_rdy  in  1  buffer accepts beat
- Bm_cnt_out  out  6  index of the beat currently presented
- batch_done  out  1  one-cycle pulse after batch wraps
- ovf  out  1  sticky: tile dropped while full

Behaviour:
- Reset (rst_cal high, async):
  - All outputs 0.
  - Tile store cleared; wr_ptr=rd_ptr=0, count=0, beat_sel=0.
- layer_start, synchronous, highest priority after reset:
  - Same clear as reset.
  - A PE_Data_I_vld in the same cycle is ignored.
- Capture:
  - PE_Data_I_vld with count<DEPTH: write the tile to entry wr_ptr, toggle wr_ptr, count+1.
  - PE_Data_I_vld with count==DEPTH: tile dropped, ovf set to 1 and held until reset or layer_start.
  - A pop in the same cycle does not rescue the tile; acceptance is decided on registered count only.
- pe_stall = (count==DEPTH), driven from registered state.
- Drain:
  - OR_Data_O_vld = (count!=0).
  - OR_Data_O = head entry lanes [8*beat_sel .. 8*beat_sel+7]; beat 0 = lanes 0-7, beat 1 = lanes 8-15.
  - No combinational path from PE_Data_I to OR_Data_O; all outputs are driven from registers.
- Handshake:
  - A beat transfers on a cycle with vld && rdy.
  - While vld && !rdy, OR_Data_O and Bm_cnt_out stay stable.
  - vld never deasserts without a transfer, except on reset or layer_start.
- On transfer:
  - beat_sel toggles.
  - When beat_sel was 1: rd_ptr toggles and count-1.
  - A simultaneous capture and pop leaves count unchanged.
- Latency: a tile captured at edge t presents beat 0 in the cycle after t; with rdy held high, beats go out on t+1 and t+2.
  - Back-to-back tiles with rdy=1 sustain 1 beat/cycle.
  - Tiles every 2 cycles never stall.
- Bm_cnt_out:
  - Increments on each transfer.
  - On the transfer at BM_BEATS-1 it wraps to 0, and batch_done pulses high in the next cycle for exactly one cycle.
- Arithmetic:
  - Bm_cnt_out is 6 bits, compared against BM_BEATS-1.
  - count is 2 bits; pointers are 1 bit.

Test Plan:
- Reset, then tile lanes 0x00..0x0F with rdy=1 -> cycle+1: vld=1, data 0x0706050403020100, Bm_cnt_out=0; cycle+2: data 0x0F0E0D0C0B0A0908, Bm_cnt_out=1; cycle+3: vld=0.
- Same tile with rdy=0 for 5 cycles, then 1 -> data/Bm_cnt_out stable at beat 0 throughout the stall, then both beats in order; no ovf.
- Three tiles on consecutive cycles with rdy=0:
  - pe_stall=1 after the 2nd capture.
  - 3rd tile dropped, ovf=1.
  - Releasing rdy gives 4 beats (tiles 1, 2) with Bm_cnt_out 0..3.
- 16 tiles drained with rdy=1 -> Bm_cnt_out runs 0..31 then 0; batch_done high for exactly one cycle after beat 31.
- Capture while the last beat of a full store drains -> tile still dropped, ovf=1, count stays 1 after the cycle.
- rst_cal asserted mid-beat-1, and separately layer_start mid-beat-1:
  - Outputs immediately 0 (reset) or next cycle 0 (layer_start); ovf cleared.
  - A following tile restarts at Bm_cnt_out=0.

Source files
------------

// File: rtl/output_regfile_packer_if.sv
// rtl/output_regfile_packer_if.sv - PE tile capture and In_Out_buffer beat bus
// master is the PE array / buffer side, slave is the packer.
interface output_regfile_packer_if #(
    parameter int LANES = 16,
    parameter int BEAT  = 8
);
    logic [LANES*8-1:0] PE_Data_I;
    logic               PE_Data_I_vld;
    logic               pe_stall;
    logic [BEAT*8-1:0]  OR_Data_O;
    logic               OR_Data_O_vld;
    logic               OR_Data_O_rdy;
    logic [5:0]         Bm_cnt_out;
    logic               batch_done;
    logic               ovf;

    modport master (
        output PE_Data_I, PE_Data_I_vld, OR_Data_O_rdy,
        input  pe_stall, OR_Data_O, OR_Data_O_vld, Bm_cnt_out, batch_done, ovf
    );

    modport slave (
        input  PE_Data_I, PE_Data_I_vld, OR_Data_O_rdy,
        output pe_stall, OR_Data_O, OR_Data_O_vld, Bm_cnt_out, batch_done, ovf
    );
endinterface

// File: rtl/output_regfile_packer.sv
// rtl/output_regfile_packer.sv - two-tile ping-pong store draining PE tiles as 8-byte beats
// Every output is a function of registered state only; PE_Data_I never reaches OR_Data_O in the same cycle.
module output_regfile_packer #(
    parameter int LANES    = 16,
    parameter int BEAT     = 8,
    parameter int DEPTH    = 2,
    parameter int BM_BEATS = 32
) (
    input  logic                   clk_cal,
    input  logic                   rst_cal,
    input  logic                   layer_start,
    output_regfile_packer_if.slave bus
);
    localparam int TW = LANES * 8;
    localparam int BW = BEAT * 8;

    logic [TW-1:0] store [DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          beat_sel;
    logic [1:0]    count;
    logic [5:0]    bm_cnt;
    logic          batch_done_q;
    logic          ovf_q;

    logic [TW-1:0] head;
    logic          xfer;
    logic          pop;
    logic          accept;
    logic          bm_last;

    assign head    = store[rd_ptr];
    assign xfer    = (count != 2'd0) && bus.OR_Data_O_rdy;
    assign pop     = xfer && beat_sel;
    // Acceptance looks at registered count only, so a same-cycle pop never frees a slot.
    assign accept  = bus.PE_Data_I_vld && (count != 2'(DEPTH));
    assign bm_last = (bm_cnt == 6'(BM_BEATS - 1));

    always_ff @(posedge clk_cal or posedge rst_cal) begin
        if (rst_cal) begin
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            beat_sel     <= 1'b0;
            count        <= 2'd0;
            bm_cnt       <= 6'd0;
            batch_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (layer_start) begin
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            beat_sel     <= 1'b0;
            count        <= 2'd0;
            bm_cnt       <= 6'd0;
            batch_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (accept) begin
                store[wr_ptr] <= bus.PE_Data_I;
                wr_ptr        <= ~wr_ptr;
            end
            if (xfer) begin
                beat_sel <= ~beat_sel;
                bm_cnt   <= bm_last ? 6'd0 : bm_cnt + 6'd1;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count        <= count + {1'b0, accept} - {1'b0, pop};
            batch_done_q <= xfer && bm_last;
            if (bus.PE_Data_I_vld && !accept) ovf_q <= 1'b1;
        end
    end

    assign bus.OR_Data_O     = beat_sel ? head[2*BW-1:BW] : head[BW-1:0];
    assign bus.OR_Data_O_vld = (count != 2'd0);
    assign bus.pe_stall      = (count == 2'(DEPTH));
    assign bus.Bm_cnt_out    = bm_cnt;
    assign bus.batch_done    = batch_done_q;
    assign bus.ovf           = ovf_q;
endmodule

// File: tb/tb_output_regfile_packer.sv
// tb/tb_output_regfile_packer.sv - vector table, corner sequences and random run against a beat-queue model
module tb_output_regfile_packer;
    logic clk_cal;
    logic rst_cal;
    logic layer_start;

    output_regfile_packer_if bus ();

    output_regfile_packer dut (
        .clk_cal     (clk_cal),
        .rst_cal     (rst_cal),
        .layer_start (layer_start),
        .bus         (bus)
    );

    initial clk_cal = 1'b0;
    always #5 clk_cal = ~clk_cal;

    int total = 0;
    int bad   = 0;

    // Model: the beats still owed to the buffer, oldest first; a tile occupies
    // the store while any of its beats is pending.
    logic [63:0] mq[$];
    int          m_bm;
    bit          m_bd;
    bit          m_ovf;

    typedef struct {
        bit          do_rst;
        bit          pv;
        int          base;
        bit          rdy;
        bit          e_vld;
        logic [63:0] e_data;
        int          e_bm;
        bit          e_stall;
        bit          e_ovf;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] ramp(input int b);
        logic [127:0] t;
        for (int n = 0; n < 16; n++) t[8*n +: 8] = 8'(b + n);
        return t;
    endfunction

    function automatic logic [63:0] beat_of(input int b);
        logic [63:0] d;
        for (int m = 0; m < 8; m++) d[8*m +: 8] = 8'(b + m);
        return d;
    endfunction

    function automatic vec_t mk(input bit r, input bit pv, input int base, input bit rdy,
                                input bit ev, input logic [63:0] ed, input int eb,
                                input bit es, input bit eo);
        vec_t v;
        v.do_rst = r; v.pv = pv; v.base = base; v.rdy = rdy;
        v.e_vld = ev; v.e_data = ed; v.e_bm = eb; v.e_stall = es; v.e_ovf = eo;
        return v;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_bm  = 0;
        m_bd  = 0;
        m_ovf = 0;
    endtask

    task automatic model_check();
        int tiles;
        tiles = (mq.size() + 1) / 2;
        chk("vld", 64'(bus.OR_Data_O_vld), 64'(mq.size() != 0));
        if (mq.size() != 0) chk("data", bus.OR_Data_O, mq[0]);
        chk("bm_cnt", 64'(bus.Bm_cnt_out), 64'(m_bm));
        chk("pe_stall", 64'(bus.pe_stall), 64'(tiles == 2));
        chk("ovf", 64'(bus.ovf), 64'(m_ovf));
        chk("batch_done", 64'(bus.batch_done), 64'(m_bd));
    endtask

    task automatic model_advance(input bit pv, input logic [127:0] tile, input bit rdy, input bit ls);
        int tiles;
        bit xfer;
        bit acc;
        tiles = (mq.size() + 1) / 2;
        xfer  = (mq.size() != 0) && rdy;
        acc   = pv && (tiles < 2);
        if (ls) begin
            model_clear();
        end else begin
            m_bd = xfer && (m_bm == 31);
            if (xfer) begin
                void'(mq.pop_front());
                m_bm = (m_bm + 1) % 32;
            end
            if (pv && !acc) m_ovf = 1;
            if (acc) begin
                mq.push_back(tile[63:0]);
                mq.push_back(tile[127:64]);
            end
        end
    endtask

    task automatic step(input bit pv, input logic [127:0] tile, input bit rdy, input bit ls);
        bus.PE_Data_I_vld = pv;
        bus.PE_Data_I     = tile;
        bus.OR_Data_O_rdy = rdy;
        layer_start       = ls;
        model_check();
        model_advance(pv, tile, rdy, ls);
        @(posedge clk_cal);
        #1;
    endtask

    task automatic do_reset();
        rst_cal           = 1'b1;
        layer_start       = 1'b0;
        bus.PE_Data_I_vld = 1'b0;
        bus.PE_Data_I     = '0;
        bus.OR_Data_O_rdy = 1'b0;
        model_clear();
        @(posedge clk_cal);
        #1;
        model_check();
        chk("rst_data", bus.OR_Data_O, 64'h0);
        rst_cal = 1'b0;
        @(posedge clk_cal);
        #1;
    endtask

    task automatic fill_three_then_beat0();
        step(1'b1, ramp(8'h40), 1'b0, 1'b0);
        step(1'b1, ramp(8'h50), 1'b0, 1'b0);
        step(1'b1, ramp(8'h60), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        int bd_cnt;

        // Single tile, rdy high: beats on the two cycles after capture.
        vt[0]  = mk(1, 1, 8'h00, 1, 0, 64'h0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0,     1, 1, beat_of(8'h00), 0, 0, 0);
        vt[2]  = mk(0, 0, 0,     1, 1, beat_of(8'h08), 1, 0, 0);
        vt[3]  = mk(0, 0, 0,     0, 0, 64'h0, 2, 0, 0);
        // Three tiles with rdy low: third dropped, then four beats.
        vt[4]  = mk(1, 1, 8'h10, 0, 0, 64'h0, 0, 0, 0);
        vt[5]  = mk(0, 1, 8'h20, 0, 1, beat_of(8'h10), 0, 0, 0);
        vt[6]  = mk(0, 1, 8'h30, 0, 1, beat_of(8'h10), 0, 1, 0);
        vt[7]  = mk(0, 0, 0,     1, 1, beat_of(8'h10), 0, 1, 1);
        vt[8]  = mk(0, 0, 0,     1, 1, beat_of(8'h18), 1, 1, 1);
        vt[9]  = mk(0, 0, 0,     1, 1, beat_of(8'h20), 2, 0, 1);
        vt[10] = mk(0, 0, 0,     1, 1, beat_of(8'h28), 3, 0, 1);
        vt[11] = mk(0, 0, 0,     0, 0, 64'h0, 4, 0, 1);

        rst_cal = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (vt[i].do_rst) do_reset();
            chk($sformatf("vec%0d_vld", i), 64'(bus.OR_Data_O_vld), 64'(vt[i].e_vld));
            if (vt[i].e_vld) chk($sformatf("vec%0d_data", i), bus.OR_Data_O, vt[i].e_data);
            chk($sformatf("vec%0d_bm", i), 64'(bus.Bm_cnt_out), 64'(vt[i].e_bm));
            chk($sformatf("vec%0d_stall", i), 64'(bus.pe_stall), 64'(vt[i].e_stall));
            chk($sformatf("vec%0d_ovf", i), 64'(bus.ovf), 64'(vt[i].e_ovf));
            step(vt[i].pv, ramp(vt[i].base), vt[i].rdy, 1'b0);
        end

        // Back-pressure: beat 0 held for five cycles, then both beats.
        do_reset();
        step(1'b1, ramp(8'h00), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Sixteen tiles every two cycles: full batch, one batch_done pulse.
        do_reset();
        bd_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            bd_cnt += int'(bus.batch_done);
            step(1'b1, ramp(i * 16), 1'b1, 1'b0);
            bd_cnt += int'(bus.batch_done);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            bd_cnt += int'(bus.batch_done);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("batch_done_pulses", 64'(bd_cnt), 64'd1);

        // Capture during the last beat of a full store is still dropped.
        do_reset();
        step(1'b1, ramp(8'h70), 1'b0, 1'b0);
        step(1'b1, ramp(8'h80), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, ramp(8'h90), 1'b1, 1'b0);
        chk("lastbeat_ovf", 64'(bus.ovf), 64'd1);
        chk("lastbeat_stall", 64'(bus.pe_stall), 64'd0);
        chk("lastbeat_data", bus.OR_Data_O, beat_of(8'h80));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset while beat 1 is presented.
        do_reset();
        fill_three_then_beat0();
        #2;
        rst_cal = 1'b1;
        #1;
        model_clear();
        model_check();
        chk("arst_data", bus.OR_Data_O, 64'h0);
        #2;
        rst_cal = 1'b0;
        @(posedge clk_cal);
        #1;
        step(1'b1, ramp(8'hA0), 1'b1, 1'b0);
        chk("arst_restart_bm", 64'(bus.Bm_cnt_out), 64'd0);
        chk("arst_restart_data", bus.OR_Data_O, beat_of(8'hA0));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // layer_start while beat 1 is presented; a same-cycle tile is ignored.
        do_reset();
        fill_three_then_beat0();
        step(1'b1, ramp(8'hB0), 1'b1, 1'b1);
        chk("ls_data", bus.OR_Data_O, 64'h0);
        step(1'b1, ramp(8'hC0), 1'b1, 1'b0);
        chk("ls_restart_bm", 64'(bus.Bm_cnt_out), 64'd0);
        chk("ls_restart_data", bus.OR_Data_O, beat_of(8'hC0));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 45),
                 {$urandom(), $urandom(), $urandom(), $urandom()},
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
